// File: rtl/wb_gpio_pkg.sv
// Register map constants shared by the Wishbone GPIO bank and its sub-blocks.
package wb_gpio_pkg;

  localparam int REG_SEL_W = 3;

  localparam logic [REG_SEL_W-1:0] REG_OUT      = 3'd0;
  localparam logic [REG_SEL_W-1:0] REG_DIR      = 3'd1;
  localparam logic [REG_SEL_W-1:0] REG_IN       = 3'd2;
  localparam logic [REG_SEL_W-1:0] REG_SET      = 3'd3;
  localparam logic [REG_SEL_W-1:0] REG_CLR      = 3'd4;
  localparam logic [REG_SEL_W-1:0] REG_TGL      = 3'd5;
  localparam logic [REG_SEL_W-1:0] REG_IRQ_EN   = 3'd6;
  localparam logic [REG_SEL_W-1:0] REG_IRQ_STAT = 3'd7;

endpackage

// File: rtl/wb_gpio_sync.sv
// One channel's 2-flop input synchroniser (2 edges to sync); with WB_GPIO_IRQ_EN a
// previous-sample flop drives the rising-edge output, otherwise rise is tied 0.
module wb_gpio_sync
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

`ifdef WB_GPIO_IRQ_EN
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= sync;
  end

  assign rise = sync & ~prev;
`else
  assign rise = '0;
`endif

endmodule

// File: rtl/wb_gpio_bank.sv
// Multi-channel Wishbone GPIO slave; ack one cycle after request, at most one ack per 2 cycles.
// WB_GPIO_IRQ_EN adds rising-edge interrupt enable/status registers and irq_o.
module wb_gpio_bank
  import wb_gpio_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int CHANNELS     = 4,
  parameter int ADDR_WIDTH   = ((3 + $clog2(CHANNELS)) < 4) ? 4 : (3 + $clog2(CHANNELS))
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          adr_i,
  input  logic [DATA_WIDTH-1:0]          dat_i,
  output logic [DATA_WIDTH-1:0]          dat_o,
  input  logic                           we_i,
  input  logic [SELECT_WIDTH-1:0]        sel_i,
  input  logic                           stb_i,
  input  logic                           cyc_i,
  output logic                           ack_o,
  output logic [CHANNELS*DATA_WIDTH-1:0] gpio_o,
  output logic [CHANNELS*DATA_WIDTH-1:0] gpio_oe_o,
  input  logic [CHANNELS*DATA_WIDTH-1:0] gpio_i,
  output logic                           irq_o
);

  localparam int LANE_W = DATA_WIDTH / SELECT_WIDTH;
  localparam int CH_W   = ADDR_WIDTH - REG_SEL_W;

  logic                                req, wr;
  logic [REG_SEL_W-1:0]                reg_sel;
  logic [CH_W-1:0]                     ch_idx;
  logic [31:0]                         ch_num;
  logic [DATA_WIDTH-1:0]               wmask, wbits, rd_data;
  logic [CHANNELS-1:0]                 wr_ch;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] out_q, dir_q, in_sync, rise_v;
`ifdef WB_GPIO_IRQ_EN
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] en_q, stat_q;
  logic                                irq_q;
`endif

  assign req     = cyc_i & stb_i & ~ack_o;
  assign wr      = req & we_i;
  assign reg_sel = adr_i[REG_SEL_W-1:0];
  assign ch_idx  = adr_i[ADDR_WIDTH-1:REG_SEL_W];
  assign ch_num  = 32'(ch_idx);
  assign wbits   = dat_i & wmask;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < SELECT_WIDTH; i++) wmask[i*LANE_W +: LANE_W] = {LANE_W{sel_i[i]}};
  end

  // Out-of-range channel numbers match no bit here, so such writes fall through silently.
  always_comb begin
    wr_ch = '0;
    for (int c = 0; c < CHANNELS; c++) wr_ch[c] = wr && (ch_num == 32'(c));
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    wb_gpio_sync #(.WIDTH(DATA_WIDTH)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (gpio_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .sync (in_sync[c]),
      .rise (rise_v[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_ch[c]) begin
          case (reg_sel)
            REG_OUT: out_q[c] <= (out_q[c] & ~wmask) | wbits;
            REG_DIR: dir_q[c] <= (dir_q[c] & ~wmask) | wbits;
            REG_SET: out_q[c] <= out_q[c] | wbits;
            REG_CLR: out_q[c] <= out_q[c] & ~wbits;
            REG_TGL: out_q[c] <= out_q[c] ^ wbits;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef WB_GPIO_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      irq_q <= |(stat_q & en_q);
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_ch[c] && reg_sel == REG_IRQ_EN) en_q[c] <= (en_q[c] & ~wmask) | wbits;
        // The edge term is ORed after the W1C so a coincident rise survives the clear.
        stat_q[c] <= (stat_q[c] & ~((wr_ch[c] && reg_sel == REG_IRQ_STAT) ? wbits : '0))
                   | (rise_v[c] & en_q[c]);
      end
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_rise;
  assign unused_rise = ^rise_v;
  assign irq_o       = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_num == 32'(c)) begin
        case (reg_sel)
          REG_OUT:      rd_data = out_q[c];
          REG_DIR:      rd_data = dir_q[c];
          REG_IN:       rd_data = in_sync[c];
`ifdef WB_GPIO_IRQ_EN
          REG_IRQ_EN:   rd_data = en_q[c];
          REG_IRQ_STAT: rd_data = stat_q[c];
`endif
          default:      rd_data = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req;
      if (req) dat_o <= rd_data;
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Directed bench for wb_gpio_bank with a per-register behavioural model and per-cycle pin checks.
module tb_wb_gpio_bank;

  localparam int CH = 4;

  logic          clk, rst;
  logic [5:0]    adr;
  logic [31:0]   dat_w, dat_r;
  logic          we, stb, cyc, ack, irq;
  logic [3:0]    sel;
  logic [127:0]  gpio_out, gpio_oe, gpio_in;

  int            total = 0;
  int            bad   = 0;
  bit            chk_on = 0;

  logic [31:0]   m_out[CH], m_dir[CH], m_en[CH], m_stat[CH];

  wb_gpio_bank #(.DATA_WIDTH(32), .SELECT_WIDTH(4), .CHANNELS(CH), .ADDR_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .adr_i     (adr),
    .dat_i     (dat_w),
    .dat_o     (dat_r),
    .we_i      (we),
    .sel_i     (sel),
    .stb_i     (stb),
    .cyc_i     (cyc),
    .ack_o     (ack),
    .gpio_o    (gpio_out),
    .gpio_oe_o (gpio_oe),
    .gpio_i    (gpio_in),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_out[c] = '0; m_dir[c] = '0; m_en[c] = '0; m_stat[c] = '0;
    end
  endfunction

  // Byte-by-byte application of the register rules; unselected bytes are untouched.
  function automatic void model_write(int ch, int rg, logic [31:0] d, logic [3:0] s);
    logic [7:0] b;
    if (ch >= CH) return;
    for (int l = 0; l < 4; l++) begin
      if (s[l]) begin
        b = d[8*l +: 8];
        case (rg)
          0: m_out[ch][8*l +: 8] = b;
          1: m_dir[ch][8*l +: 8] = b;
          3: m_out[ch][8*l +: 8] = m_out[ch][8*l +: 8] | b;
          4: m_out[ch][8*l +: 8] = m_out[ch][8*l +: 8] & ~b;
          5: m_out[ch][8*l +: 8] = m_out[ch][8*l +: 8] ^ b;
`ifdef WB_GPIO_IRQ_EN
          6: m_en[ch][8*l +: 8]   = b;
          7: m_stat[ch][8*l +: 8] = m_stat[ch][8*l +: 8] & ~b;
`endif
          default: ;
        endcase
      end
    end
  endfunction

  // IN is modelled as the settled pin value; reads of IN right after a pin change skip this.
  function automatic logic [31:0] model_read(int ch, int rg);
    if (ch >= CH) return '0;
    case (rg)
      0: return m_out[ch];
      1: return m_dir[ch];
      2: return gpio_in[32*ch +: 32];
`ifdef WB_GPIO_IRQ_EN
      6: return m_en[ch];
      7: return m_stat[ch];
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic [127:0] pack_out();
    logic [127:0] p;
    for (int c = 0; c < CH; c++) p[32*c +: 32] = m_out[c];
    return p;
  endfunction

  function automatic logic [127:0] pack_dir();
    logic [127:0] p;
    for (int c = 0; c < CH; c++) p[32*c +: 32] = m_dir[c];
    return p;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_gpio_o", gpio_out, pack_out());
      chk("cmp_gpio_oe", gpio_oe, pack_dir());
    end
  end

  task automatic bus(input string name, input int pre, input bit wr, input int ch, input int rg,
                     input logic [31:0] d, input logic [3:0] s, input bit mchk,
                     output logic [31:0] rd);
    int          n;
    logic [31:0] exp;
    repeat (pre) @(posedge clk);
    #1;
    exp   = model_read(ch, rg);
    adr   = 6'((ch << 3) | rg);
    we    = wr;
    dat_w = d;
    sel   = s;
    cyc   = 1'b1;
    stb   = 1'b1;
    n     = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack && n < 8);
    chk({name, "_ack_lat"}, 128'(n), 128'd1);
    rd  = dat_r;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    if (ack) begin
      if (wr) model_write(ch, rg, d, s);
      else if (mchk) chk({name, "_rd"}, 128'(rd), 128'(exp));
    end
  endtask

  logic [31:0] rd;
  int          acks;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
    gpio_in = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 128'(ack), 128'd0);
    chk("rst_dat", 128'(dat_r), 128'd0);
    chk("rst_gpio_o", gpio_out, 128'd0);
    chk("rst_gpio_oe", gpio_oe, 128'd0);
    chk("rst_irq", 128'(irq), 128'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_on = 1'b1;

    bus("ch0_out", 1, 1'b0, 0, 0, 32'h0, 4'h0, 1'b1, rd);
    chk("ch0_out_lit", 128'(rd), 128'd0);

    // Lane-masked write over a zero register.
    bus("ch1_out_w", 1, 1'b1, 1, 0, 32'hDEADBEEF, 4'b0101, 1'b1, rd);
    @(negedge clk);
    chk("ch1_gpio_lit", 128'(gpio_out[63:32]), 128'h00AD00EF);
    bus("ch1_out_r", 1, 1'b0, 1, 0, 32'h0, 4'h0, 1'b1, rd);
    chk("ch1_out_lit", 128'(rd), 128'h00AD00EF);
    bus("ch1_dir_w", 1, 1'b1, 1, 1, 32'hA5A5A5A5, 4'b1100, 1'b1, rd);
    bus("ch1_dir_r", 1, 1'b0, 1, 1, 32'h0, 4'h0, 1'b1, rd);
    chk("ch1_dir_lit", 128'(rd), 128'hA5A50000);

    // Atomic aliases.
    bus("ch2_out_w", 1, 1'b1, 2, 0, 32'h0000FF00, 4'hF, 1'b1, rd);
    bus("ch2_set_w", 1, 1'b1, 2, 3, 32'h000000F0, 4'hF, 1'b1, rd);
    bus("ch2_clr_w", 1, 1'b1, 2, 4, 32'h00000F00, 4'hF, 1'b1, rd);
    bus("ch2_tgl_w", 1, 1'b1, 2, 5, 32'hFFFF0000, 4'hF, 1'b1, rd);
    bus("ch2_out_r", 1, 1'b0, 2, 0, 32'h0, 4'h0, 1'b1, rd);
    chk("ch2_out_lit", 128'(rd), 128'hFFFFF0F0);
    bus("ch2_set_r", 1, 1'b0, 2, 3, 32'h0, 4'h0, 1'b1, rd);
    chk("ch2_set_lit", 128'(rd), 128'd0);
    bus("ch2_clr_r", 1, 1'b0, 2, 4, 32'h0, 4'h0, 1'b1, rd);
    bus("ch2_tgl_r", 1, 1'b0, 2, 5, 32'h0, 4'h0, 1'b1, rd);
    bus("ch2_set_lane", 1, 1'b1, 2, 3, 32'hFFFFFFFF, 4'b0001, 1'b1, rd);
    bus("ch2_out_r2", 1, 1'b0, 2, 0, 32'h0, 4'h0, 1'b1, rd);
    chk("ch2_out_lit2", 128'(rd), 128'hFFFFF0FF);

    // Input latency: a read started 1 edge after the change misses it, 2 edges after sees it.
    gpio_in[96+5] = 1'b1;
    bus("ch3_in_early", 1, 1'b0, 3, 2, 32'h0, 4'h0, 1'b0, rd);
    chk("ch3_in_early_lit", 128'(rd), 128'd0);
    gpio_in[96+6] = 1'b1;
    bus("ch3_in_late", 2, 1'b0, 3, 2, 32'h0, 4'h0, 1'b0, rd);
    chk("ch3_in_late_lit", 128'(rd), 128'h60);
    bus("ch3_in", 1, 1'b0, 3, 2, 32'h0, 4'h0, 1'b1, rd);

    // Channels beyond the bank: acked, read 0, no effect.
    bus("ch5_out_w", 1, 1'b1, 5, 0, 32'hFFFFFFFF, 4'hF, 1'b1, rd);
    bus("ch7_set_w", 1, 1'b1, 7, 3, 32'hFFFFFFFF, 4'hF, 1'b1, rd);
    bus("ch5_out_r", 1, 1'b0, 5, 0, 32'h0, 4'h0, 1'b1, rd);
    chk("ch5_out_lit", 128'(rd), 128'd0);
    bus("ch4_in_r", 1, 1'b0, 4, 2, 32'h0, 4'h0, 1'b1, rd);

`ifdef WB_GPIO_IRQ_EN
    bus("ch0_en_w", 1, 1'b1, 0, 6, 32'h1, 4'hF, 1'b1, rd);
    gpio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_pre", 128'(irq), 128'd0);
    @(posedge clk);
    #1;
    chk("irq_set", 128'(irq), 128'd1);
    m_stat[0][0] = 1'b1;
    gpio_in[0]   = 1'b0;
    bus("ch0_stat_r", 1, 1'b0, 0, 7, 32'h0, 4'h0, 1'b1, rd);
    chk("ch0_stat_lit", 128'(rd), 128'd1);
    bus("ch0_w1c", 1, 1'b1, 0, 7, 32'h1, 4'hF, 1'b1, rd);
    chk("irq_hold", 128'(irq), 128'd1);
    @(posedge clk);
    #1;
    chk("irq_clr", 128'(irq), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    // New rises on bits 0 and 1 timed to land on the W1C edge; only bit 0 is enabled.
    gpio_in[1:0] = 2'b11;
    bus("ch0_w1c_edge", 2, 1'b1, 0, 7, 32'h1, 4'hF, 1'b1, rd);
    m_stat[0][0] = 1'b1;
    bus("ch0_stat_r2", 1, 1'b0, 0, 7, 32'h0, 4'h0, 1'b1, rd);
    chk("ch0_stat_lit2", 128'(rd), 128'd1);
    chk("irq_edge", 128'(irq), 128'd1);
`else
    bus("ch0_en_w", 1, 1'b1, 0, 6, 32'hFFFFFFFF, 4'hF, 1'b1, rd);
    bus("ch0_en_r", 1, 1'b0, 0, 6, 32'h0, 4'h0, 1'b1, rd);
    chk("ch0_en_lit", 128'(rd), 128'd0);
    gpio_in[0] = 1'b1;
    repeat (6) @(posedge clk);
    bus("ch0_stat_r", 1, 1'b0, 0, 7, 32'h0, 4'h0, 1'b1, rd);
    chk("ch0_stat_lit", 128'(rd), 128'd0);
    chk("irq_off", 128'(irq), 128'd0);
`endif

    // Held strobe: one ack every other cycle, each one a committed toggle.
    @(posedge clk);
    #1;
    adr = 6'(5); we = 1'b1; dat_w = 32'h1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        acks++;
        model_write(0, 5, 32'h1, 4'hF);
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("held_acks", 128'(acks), 128'd3);
    bus("ch0_out_held", 1, 1'b0, 0, 0, 32'h0, 4'h0, 1'b1, rd);
    chk("ch0_out_held_lit", 128'(rd), 128'd1);

    // Reset while ack is high, with the master still requesting a write.
    @(posedge clk);
    #1;
    adr = 6'(8); we = 1'b1; dat_w = 32'h12345678; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pre_ack", 128'(ack), 128'd1);
    model_write(1, 0, 32'h12345678, 4'hF);
    rst   = 1'b1;
    dat_w = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_ack_drop", 128'(ack), 128'd0);
    chk("rst_mid_gpio_o", gpio_out, 128'd0);
    chk("rst_mid_gpio_oe", gpio_oe, 128'd0);
    chk("rst_mid_dat", 128'(dat_r), 128'd0);
    chk("rst_mid_irq", 128'(irq), 128'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus("ch1_out_post", 1, 1'b0, 1, 0, 32'h0, 4'h0, 1'b1, rd);
    chk("ch1_out_post_lit", 128'(rd), 128'd0);
    bus("ch1_dir_post", 1, 1'b0, 1, 1, 32'h0, 4'h0, 1'b1, rd);
    bus("ch2_out_post", 1, 1'b0, 2, 0, 32'h0, 4'h0, 1'b1, rd);

    repeat (2) @(posedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
